// File: rtl/cpu_control_multi.sv
`default_nettype none
// ============================================================================
// Module  : cpu_control_multi
// Brief   : Multi-cycle IF/ID/EXE/MEM/WB sequencer for the MIPS-subset datapath
//           with a shared memory port and a memory wait watchdog.
// Revision: 1.0 - initial release
// ============================================================================
module cpu_control_multi #(
    parameter int WAIT_MAX = 255
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [5:0] op,
    input  logic [5:0] func,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       iord,
    output logic       wmem,
    output logic       wir,
    output logic       wpc,
    output logic [1:0] pcsource,
    output logic       wreg,
    output logic       regrt,
    output logic       m2reg,
    output logic       jal,
    output logic [3:0] aluc,
    output logic       shift,
    output logic       aluimm,
    output logic       sext,
    output logic [2:0] state,
    output logic       illegal,
    output logic       bus_err
);

    localparam logic [2:0] c_st_if  = 3'd0;
    localparam logic [2:0] c_st_id  = 3'd1;
    localparam logic [2:0] c_st_exe = 3'd2;
    localparam logic [2:0] c_st_mem = 3'd3;
    localparam logic [2:0] c_st_wb  = 3'd4;

    localparam logic [3:0] c_k_alu = 4'd0;
    localparam logic [3:0] c_k_lw  = 4'd1;
    localparam logic [3:0] c_k_sw  = 4'd2;
    localparam logic [3:0] c_k_beq = 4'd3;
    localparam logic [3:0] c_k_bne = 4'd4;
    localparam logic [3:0] c_k_j   = 4'd5;
    localparam logic [3:0] c_k_jal = 4'd6;
    localparam logic [3:0] c_k_jr  = 4'd7;
    localparam logic [3:0] c_k_ill = 4'd8;

    localparam logic [15:0] c_wait_max = 16'(WAIT_MAX);

    logic [2:0]  r_state;
    logic [15:0] r_wait_cnt;
    logic [3:0]  w_kind;
    logic [2:0]  w_next;
    logic        w_mem_phase;
    logic        w_expire;
    logic        w_wir;
    logic        w_wpc;
    logic        w_wreg;
    logic        w_illegal;

    // Instruction decode; every field stays 0 for an unsupported op/func.
    always_comb begin
        w_kind = c_k_ill;
        regrt  = 1'b0;
        m2reg  = 1'b0;
        jal    = 1'b0;
        aluc   = 4'b0000;
        shift  = 1'b0;
        aluimm = 1'b0;
        sext   = 1'b0;
        case (op)
            6'h00: begin
                case (func)
                    6'h20: begin w_kind = c_k_alu; aluc = 4'b0000; end
                    6'h22: begin w_kind = c_k_alu; aluc = 4'b0100; end
                    6'h24: begin w_kind = c_k_alu; aluc = 4'b0001; end
                    6'h25: begin w_kind = c_k_alu; aluc = 4'b0101; end
                    6'h26: begin w_kind = c_k_alu; aluc = 4'b0010; end
                    6'h00: begin w_kind = c_k_alu; aluc = 4'b0011; shift = 1'b1; end
                    6'h02: begin w_kind = c_k_alu; aluc = 4'b0111; shift = 1'b1; end
                    6'h03: begin w_kind = c_k_alu; aluc = 4'b1111; shift = 1'b1; end
                    6'h08: w_kind = c_k_jr;
                    default: w_kind = c_k_ill;
                endcase
            end
            6'h08: begin w_kind = c_k_alu; aluc = 4'b0000; regrt = 1'b1; aluimm = 1'b1; sext = 1'b1; end
            6'h0C: begin w_kind = c_k_alu; aluc = 4'b0001; regrt = 1'b1; aluimm = 1'b1; end
            6'h0D: begin w_kind = c_k_alu; aluc = 4'b0101; regrt = 1'b1; aluimm = 1'b1; end
            6'h0E: begin w_kind = c_k_alu; aluc = 4'b0010; regrt = 1'b1; aluimm = 1'b1; end
            6'h0F: begin w_kind = c_k_alu; aluc = 4'b0110; regrt = 1'b1; aluimm = 1'b1; end
            6'h23: begin
                w_kind = c_k_lw; regrt = 1'b1; m2reg = 1'b1; aluimm = 1'b1; sext = 1'b1;
            end
            6'h2B: begin w_kind = c_k_sw;  aluimm = 1'b1; sext = 1'b1; end
            6'h04: begin w_kind = c_k_beq; aluc = 4'b0100; sext = 1'b1; end
            6'h05: begin w_kind = c_k_bne; aluc = 4'b0100; sext = 1'b1; end
            6'h02: w_kind = c_k_j;
            6'h03: begin w_kind = c_k_jal; jal = 1'b1; end
            default: w_kind = c_k_ill;
        endcase
    end

    // Expiry only when the memory is still silent; a late ready completes normally.
    assign w_mem_phase = (r_state == c_st_if) || (r_state == c_st_mem);
    assign w_expire    = w_mem_phase && !mem_ready && (r_wait_cnt == c_wait_max);

    always_comb begin
        w_next    = r_state;
        w_wir     = 1'b0;
        w_wpc     = 1'b0;
        w_wreg    = 1'b0;
        w_illegal = 1'b0;
        pcsource  = 2'b00;
        case (r_state)
            c_st_if: begin
                if (mem_ready) begin
                    w_wir  = 1'b1;
                    w_wpc  = 1'b1;
                    w_next = c_st_id;
                end else if (w_expire) begin
                    w_next = c_st_if;
                end
            end
            c_st_id: begin
                w_next = c_st_if;
                case (w_kind)
                    c_k_j:   begin w_wpc = 1'b1; pcsource = 2'b11; end
                    c_k_jal: begin w_wpc = 1'b1; w_wreg = 1'b1; pcsource = 2'b11; end
                    c_k_jr:  begin w_wpc = 1'b1; pcsource = 2'b10; end
                    c_k_ill: w_illegal = 1'b1;
                    default: w_next = c_st_exe;
                endcase
            end
            c_st_exe: begin
                case (w_kind)
                    c_k_beq: begin w_wpc = zero;  pcsource = 2'b01; w_next = c_st_if; end
                    c_k_bne: begin w_wpc = !zero; pcsource = 2'b01; w_next = c_st_if; end
                    c_k_lw, c_k_sw: w_next = c_st_mem;
                    default: w_next = c_st_wb;
                endcase
            end
            c_st_mem: begin
                if (mem_ready) begin
                    w_next = (w_kind == c_k_sw) ? c_st_if : c_st_wb;
                end else if (w_expire) begin
                    w_next = c_st_if;
                end
            end
            c_st_wb: begin
                w_wreg = 1'b1;
                w_next = c_st_if;
            end
            default: w_next = c_st_if;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= c_st_if;
            r_wait_cnt <= 16'd0;
        end else begin
            r_state <= w_next;
            if (w_mem_phase && !mem_ready && !w_expire) begin
                r_wait_cnt <= r_wait_cnt + 16'd1;
            end else begin
                r_wait_cnt <= 16'd0;
            end
        end
    end

    // Every enable is held low for as long as reset is asserted.
    assign mem_req = reset_n && w_mem_phase && !w_expire;
    assign iord    = (r_state == c_st_mem);
    assign wmem    = reset_n && (r_state == c_st_mem) && (w_kind == c_k_sw) && !w_expire;
    assign wir     = reset_n && w_wir;
    assign wpc     = reset_n && w_wpc;
    assign wreg    = reset_n && w_wreg;
    assign illegal = reset_n && w_illegal;
    assign bus_err = reset_n && w_expire;
    assign state   = r_state;

endmodule
`default_nettype wire

// File: tb/tb_cpu_control_multi.sv
`default_nettype none
// ============================================================================
// Module  : tb_cpu_control_multi
// Brief   : Directed bench for cpu_control_multi against a per-instruction
//           cycle-trace model and a decode table.
// Revision: 1.0 - initial release
// ============================================================================
module tb_cpu_control_multi;

    localparam int WM = 4;

    localparam int K_ALU = 0, K_LW = 1, K_SW = 2, K_BEQ = 3, K_BNE = 4,
                   K_J = 5, K_JAL = 6, K_JR = 7, K_ILL = 8;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [5:0] op = 6'h00;
    logic [5:0] func = 6'h20;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       mem_req, iord, wmem, wir, wpc, wreg;
    logic [1:0] pcsource;
    logic       regrt, m2reg, jal, shift, aluimm, sext;
    logic [3:0] aluc;
    logic [2:0] state;
    logic       illegal, bus_err;

    cpu_control_multi #(.WAIT_MAX(WM)) dut (
        .clock(clock), .reset_n(reset_n), .op(op), .func(func), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .iord(iord), .wmem(wmem),
        .wir(wir), .wpc(wpc), .pcsource(pcsource), .wreg(wreg), .regrt(regrt),
        .m2reg(m2reg), .jal(jal), .aluc(aluc), .shift(shift), .aluimm(aluimm),
        .sext(sext), .state(state), .illegal(illegal), .bus_err(bus_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       rdy;
        logic [2:0] st;
        logic       mreq, iord, wmem, wir, wpc, wreg, ill, berr;
        logic [1:0] pcs;
    } cyc_t;

    typedef struct {
        logic       regrt, m2reg, jal, shift, aluimm, sext;
        logic [3:0] aluc, mask;
    } dec_t;

    typedef struct {
        logic [5:0] op, func;
        logic       z;
        int         ifw, memw, lat;
    } vec_t;

    cyc_t q[$];
    cyc_t exp_c;
    logic exp_valid = 1'b0;
    int   checks = 0;
    int   passes = 0;
    int   berr_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act === expv) passes++;
        else $display("FAIL %s actual=%h expected=%h at t=%0t", name, act, expv, $time);
    endtask

    function automatic int kind_of(input logic [5:0] o, input logic [5:0] f);
        if (o == 6'h00) begin
            if (f inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h00, 6'h02, 6'h03}) return K_ALU;
            if (f == 6'h08) return K_JR;
            return K_ILL;
        end
        if (o inside {6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h0F}) return K_ALU;
        if (o == 6'h23) return K_LW;
        if (o == 6'h2B) return K_SW;
        if (o == 6'h04) return K_BEQ;
        if (o == 6'h05) return K_BNE;
        if (o == 6'h02) return K_J;
        if (o == 6'h03) return K_JAL;
        return K_ILL;
    endfunction

    // Expected decode; mask drops aluc bits the instruction set leaves free.
    function automatic dec_t dec_ref(input logic [5:0] o, input logic [5:0] f);
        dec_t d;
        d = '{regrt: 1'b0, m2reg: 1'b0, jal: 1'b0, shift: 1'b0, aluimm: 1'b0,
              sext: 1'b0, aluc: 4'b0000, mask: 4'b0111};
        case ({o, f})
            {6'h00, 6'h20}: d.aluc = 4'b0000;
            {6'h00, 6'h22}: d.aluc = 4'b0100;
            {6'h00, 6'h24}: d.aluc = 4'b0001;
            {6'h00, 6'h25}: d.aluc = 4'b0101;
            {6'h00, 6'h26}: d.aluc = 4'b0010;
            {6'h00, 6'h00}: begin d.aluc = 4'b0011; d.mask = 4'b1111; d.shift = 1'b1; end
            {6'h00, 6'h02}: begin d.aluc = 4'b0111; d.mask = 4'b1111; d.shift = 1'b1; end
            {6'h00, 6'h03}: begin d.aluc = 4'b1111; d.mask = 4'b1111; d.shift = 1'b1; end
            {6'h00, 6'h08}: d.mask = 4'b0000;
            default: begin
                case (o)
                    6'h08: begin d.regrt = 1; d.aluimm = 1; d.sext = 1; d.aluc = 4'b0000; end
                    6'h0C: begin d.regrt = 1; d.aluimm = 1; d.aluc = 4'b0001; end
                    6'h0D: begin d.regrt = 1; d.aluimm = 1; d.aluc = 4'b0101; end
                    6'h0E: begin d.regrt = 1; d.aluimm = 1; d.aluc = 4'b0010; end
                    6'h0F: begin d.regrt = 1; d.aluimm = 1; d.aluc = 4'b0110; end
                    6'h23: begin d.regrt = 1; d.m2reg = 1; d.aluimm = 1; d.sext = 1; end
                    6'h2B: begin d.aluimm = 1; d.sext = 1; end
                    6'h04, 6'h05: begin d.sext = 1; d.aluc = 4'b0100; end
                    6'h02: d.mask = 4'b0000;
                    6'h03: begin d.jal = 1; d.mask = 4'b0000; end
                    default: d.mask = 4'b1111;
                endcase
            end
        endcase
        return d;
    endfunction

    function automatic cyc_t blank(input logic [2:0] st, input logic rdy);
        cyc_t c;
        c = '{rdy: rdy, st: st, mreq: 1'b0, iord: 1'b0, wmem: 1'b0, wir: 1'b0,
              wpc: 1'b0, wreg: 1'b0, ill: 1'b0, berr: 1'b0, pcs: 2'b00};
        return c;
    endfunction

    // A memory phase: w silent cycles then ready, unless the watchdog runs out first.
    task automatic push_wait(input logic is_mem, input int w, input logic is_sw, output logic done);
        cyc_t c;
        done = 1'b0;
        for (int k = 0; k <= w; k++) begin
            c = blank(is_mem ? 3'd3 : 3'd0, k == w);
            c.iord = is_mem;
            if (k < w && k == WM) begin
                c.berr = 1'b1;
                q.push_back(c);
                return;
            end
            c.mreq = 1'b1;
            c.wmem = is_mem && is_sw;
            if (k == w && !is_mem) begin
                c.wir = 1'b1;
                c.wpc = 1'b1;
            end
            q.push_back(c);
        end
        done = 1'b1;
    endtask

    task automatic build(input logic [5:0] o, input logic [5:0] f, input logic z,
                         input int ifw, input int memw);
        int   k;
        logic ok;
        cyc_t c;
        k = kind_of(o, f);
        q.delete();
        push_wait(1'b0, ifw, 1'b0, ok);
        if (!ok) return;
        c = blank(3'd1, 1'b1);
        case (k)
            K_J:   begin c.wpc = 1; c.pcs = 2'b11; end
            K_JAL: begin c.wpc = 1; c.wreg = 1; c.pcs = 2'b11; end
            K_JR:  begin c.wpc = 1; c.pcs = 2'b10; end
            K_ILL: c.ill = 1;
            default: ;
        endcase
        q.push_back(c);
        if (k inside {K_J, K_JAL, K_JR, K_ILL}) return;
        c = blank(3'd2, 1'b1);
        if (k == K_BEQ) begin c.wpc = z;  c.pcs = 2'b01; end
        if (k == K_BNE) begin c.wpc = !z; c.pcs = 2'b01; end
        q.push_back(c);
        if (k == K_BEQ || k == K_BNE) return;
        if (k == K_LW || k == K_SW) begin
            push_wait(1'b1, memw, k == K_SW, ok);
            if (!ok || k == K_SW) return;
        end
        c = blank(3'd4, 1'b1);
        c.wreg = 1'b1;
        q.push_back(c);
    endtask

    // Entered and left at posedge+1; limit < 0 plays the whole trace.
    task automatic run_instr(input vec_t v, input int limit);
        int n;
        build(v.op, v.func, v.z, v.ifw, v.memw);
        check($sformatf("latency op=%h func=%h", v.op, v.func), q.size(), v.lat);
        op   = v.op;
        func = v.func;
        zero = v.z;
        n = (limit < 0) ? q.size() : limit;
        for (int i = 0; i < n; i++) begin
            exp_c     = q[i];
            mem_ready = q[i].rdy;
            exp_valid = 1'b1;
            @(posedge clock);
            #1;
        end
        exp_valid = 1'b0;
    endtask

    always @(negedge clock) begin
        dec_t d;
        if (exp_valid) begin
            check("ctrl {st,req,iord,wmem,wir,wpc,wreg,ill,berr}",
                  {state, mem_req, iord, wmem, wir, wpc, wreg, illegal, bus_err},
                  {exp_c.st, exp_c.mreq, exp_c.iord, exp_c.wmem, exp_c.wir, exp_c.wpc,
                   exp_c.wreg, exp_c.ill, exp_c.berr});
            if (exp_c.wpc) check("pcsource", pcsource, exp_c.pcs);
            d = dec_ref(op, func);
            check("decode {regrt,m2reg,jal,aluc,shift,aluimm,sext}",
                  {regrt, m2reg, jal, aluc & d.mask, shift, aluimm, sext},
                  {d.regrt, d.m2reg, d.jal, d.aluc & d.mask, d.shift, d.aluimm, d.sext});
        end
        if (bus_err === 1'b1) berr_seen++;
    end

    task automatic check_reset_quiet(input string tag);
        check({tag, " enables"}, {mem_req, wmem, wir, wpc, wreg, illegal, bus_err}, 7'b0);
        check({tag, " state"}, state, 3'd0);
    endtask

    localparam int NV = 30;
    vec_t tv [NV] = '{
        '{6'h00, 6'h20, 1'b0, 0, 0, 4},   // add
        '{6'h00, 6'h22, 1'b0, 0, 0, 4},   // sub
        '{6'h00, 6'h24, 1'b0, 0, 0, 4},   // and
        '{6'h00, 6'h25, 1'b0, 0, 0, 4},   // or
        '{6'h00, 6'h26, 1'b0, 0, 0, 4},   // xor
        '{6'h00, 6'h00, 1'b0, 0, 0, 4},   // sll
        '{6'h00, 6'h02, 1'b0, 0, 0, 4},   // srl
        '{6'h00, 6'h03, 1'b0, 0, 0, 4},   // sra
        '{6'h08, 6'h15, 1'b0, 0, 0, 4},   // addi
        '{6'h0C, 6'h00, 1'b0, 0, 0, 4},   // andi
        '{6'h0D, 6'h01, 1'b0, 0, 0, 4},   // ori
        '{6'h0E, 6'h02, 1'b0, 0, 0, 4},   // xori
        '{6'h0F, 6'h03, 1'b0, 0, 0, 4},   // lui
        '{6'h23, 6'h00, 1'b0, 0, 3, 8},   // lw, 3 wait cycles in MEM
        '{6'h2B, 6'h00, 1'b0, 0, 3, 7},   // sw, 3 wait cycles in MEM
        '{6'h23, 6'h00, 1'b0, 0, 0, 5},   // lw
        '{6'h2B, 6'h00, 1'b0, 0, 0, 4},   // sw
        '{6'h04, 6'h00, 1'b1, 0, 0, 3},   // beq taken
        '{6'h04, 6'h00, 1'b0, 0, 0, 3},   // beq not taken
        '{6'h05, 6'h00, 1'b1, 0, 0, 3},   // bne not taken
        '{6'h05, 6'h00, 1'b0, 0, 0, 3},   // bne taken
        '{6'h03, 6'h00, 1'b0, 0, 0, 2},   // jal
        '{6'h02, 6'h00, 1'b0, 0, 0, 2},   // j
        '{6'h00, 6'h08, 1'b0, 0, 0, 2},   // jr
        '{6'h3F, 6'h00, 1'b0, 0, 0, 2},   // illegal op
        '{6'h00, 6'h3F, 1'b0, 0, 0, 2},   // illegal func
        '{6'h00, 6'h20, 1'b0, 2, 0, 6},   // add, 2 fetch waits
        '{6'h00, 6'h20, 1'b0, 9, 0, 5},   // fetch watchdog expiry
        '{6'h00, 6'h20, 1'b0, 4, 0, 8},   // ready on the expiry cycle wins
        '{6'h23, 6'h00, 1'b0, 0, 9, 8}    // MEM watchdog expiry
    };

    initial begin
        vec_t v;
        reset_n   = 1'b0;
        mem_ready = 1'b1;
        repeat (2) begin
            @(negedge clock);
            check_reset_quiet("reset");
        end
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        for (int i = 0; i < NV; i++) run_instr(tv[i], -1);
        check("bus_err pulse count", berr_seen, 2);

        // Abort a store mid-MEM: write enable must vanish as reset asserts.
        v = '{6'h2B, 6'h00, 1'b0, 0, 3, 7};
        run_instr(v, 4);
        mem_ready = 1'b0;
        #1;
        check("pre-abort wmem", {wmem, mem_req, state}, {1'b1, 1'b1, 3'd3});
        reset_n = 1'b0;
        #1;
        check_reset_quiet("abort");
        @(negedge clock);
        check_reset_quiet("abort hold");
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        v = '{6'h00, 6'h20, 1'b0, 0, 0, 4};
        run_instr(v, -1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
